// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS main control: FSM states,
// opcodes, datapath select codes and the packed control word.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IMMEX  = 4'd10,
        S_IMMWB  = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/mc_outdec.sv
// Combinational state-to-control-word decoder for the multi-cycle control.
// Only FETCH looks at mem_ready, to gate the IR and PC loads.
import mc_pkg::*;

module mc_outdec (
    input  state_t     state,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                // ALUOut captures the branch target speculatively
                ctrl.alu_src_b = SRCB_IMM_SH;
            end
            S_MEMADR, S_IMMEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RT;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_IMMWB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS main control FSM: state register, next-state logic,
// sticky illegal flag. Define MC_PERF_CNT_EN for cycle/instruction counters.
//
// state  | meaning
// FETCH  | read instruction at PC, PC += 4 on mem_ready
// DECODE | dispatch on opcode, precompute branch target
// MEMADR | base + offset for lw/sw
// MEMRD  | data read, wait for mem_ready
// MEMWB  | MDR -> rt
// MEMWR  | data write, wait for mem_ready
// EXEC   | R-type ALU op
// ALUWB  | ALUOut -> rd
// BRANCH | beq compare and conditional PC load
// JUMP   | PC <= jump target
// IMMEX  | rs + signext
// IMMWB  | ALUOut -> rt
// TRAP   | unsupported opcode, absorbing until reset
import mc_pkg::*;

module mc_control (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    state_t state_q, state_d;
    ctrl_t  ctrl_dec, ctrl;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            illegal <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == S_TRAP)
                illegal <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_IMMEX;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_IMMEX:  state_d = S_IMMWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_IMMWB: state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    mc_outdec u_outdec (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_dec)
    );

    // FETCH decodes to an active read, so strobes are masked while in reset
    assign ctrl = reset_n ? ctrl_dec : '0;

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;

`ifdef MC_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (state_q != S_TRAP)
                cycle_cnt <= cycle_cnt + 32'd1;
            if (state_d == S_FETCH && state_q != S_FETCH)
                instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_control.sv
// Directed, table-driven bench for mc_control: per-cycle vectors of
// {reset_n, opcode, mem_ready} against hand-computed control words.
module tb_mc_control;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    always #5 clk = ~clk;

    mc_control dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .illegal     (illegal)
`ifdef MC_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt)
`endif
    );

    typedef struct {
        string      name;
        logic       rst_n;
        logic [5:0] op;
        logic       rdy;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [16:0] obs;
    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                  RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal};

    // control word builder, field order matches obs
    function automatic logic [15:0] cw(input logic pcw, input logic pcwc, input logic iord,
                                       input logic mr, input logic mw, input logic irw,
                                       input logic m2r, input logic rd, input logic rw,
                                       input logic asa, input logic [1:0] asb,
                                       input logic [1:0] aop, input logic [1:0] psrc);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc};
    endfunction

    logic [15:0] C_ZERO, C_FRDY, C_FWAIT, C_DEC, C_MA, C_MR, C_MWB, C_MWR;
    logic [15:0] C_EX, C_AWB, C_BR, C_JMP, C_IMX, C_IWB;

    function automatic vec_t v(input string nm, input logic r, input logic [5:0] op,
                               input logic rdy, input logic [15:0] c, input logic ill);
        vec_t t;
        t.name = nm; t.rst_n = r; t.op = op; t.rdy = rdy; t.exp = {c, ill};
        return t;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        @(posedge clk);
        #1;
        reset_n   = t.rst_n;
        opcode    = t.op;
        mem_ready = t.rdy;
        @(negedge clk);
        check(t.name, {15'd0, obs}, {15'd0, t.exp});
    endtask

    initial begin
        int lat;
        int stalls;
        C_ZERO  = '0;
        C_FRDY  = cw(1,0,0,1,0,1,0,0,0,0,2'd1,2'd0,2'd0);
        C_FWAIT = cw(0,0,0,1,0,0,0,0,0,0,2'd1,2'd0,2'd0);
        C_DEC   = cw(0,0,0,0,0,0,0,0,0,0,2'd3,2'd0,2'd0);
        C_MA    = cw(0,0,0,0,0,0,0,0,0,1,2'd2,2'd0,2'd0);
        C_MR    = cw(0,0,1,1,0,0,0,0,0,0,2'd0,2'd0,2'd0);
        C_MWB   = cw(0,0,0,0,0,0,1,0,1,0,2'd0,2'd0,2'd0);
        C_MWR   = cw(0,0,1,0,1,0,0,0,0,0,2'd0,2'd0,2'd0);
        C_EX    = cw(0,0,0,0,0,0,0,0,0,1,2'd0,2'd2,2'd0);
        C_AWB   = cw(0,0,0,0,0,0,0,1,1,0,2'd0,2'd0,2'd0);
        C_BR    = cw(0,1,0,0,0,0,0,0,0,1,2'd0,2'd1,2'd1);
        C_JMP   = cw(1,0,0,0,0,0,0,0,0,0,2'd0,2'd0,2'd2);
        C_IMX   = cw(0,0,0,0,0,0,0,0,0,1,2'd2,2'd0,2'd0);
        C_IWB   = cw(0,0,0,0,0,0,0,0,1,0,2'd0,2'd0,2'd0);

        vecs.push_back(v("rst0",   0, 6'h23, 1, C_ZERO, 0));
        vecs.push_back(v("rst1",   0, 6'h23, 1, C_ZERO, 0));
        vecs.push_back(v("lw_f",   1, 6'h23, 1, C_FRDY, 0));
        vecs.push_back(v("lw_d",   1, 6'h23, 0, C_DEC,  0));
        vecs.push_back(v("lw_ma",  1, 6'h23, 0, C_MA,   0));
        vecs.push_back(v("lw_mr",  1, 6'h23, 1, C_MR,   0));
        vecs.push_back(v("lw_wb",  1, 6'h23, 0, C_MWB,  0));
        vecs.push_back(v("sw_f",   1, 6'h2B, 1, C_FRDY, 0));
        vecs.push_back(v("sw_d",   1, 6'h2B, 1, C_DEC,  0));
        vecs.push_back(v("sw_ma",  1, 6'h2B, 1, C_MA,   0));
        vecs.push_back(v("sw_w0",  1, 6'h2B, 0, C_MWR,  0));
        vecs.push_back(v("sw_w1",  1, 6'h2B, 0, C_MWR,  0));
        vecs.push_back(v("sw_w2",  1, 6'h2B, 0, C_MWR,  0));
        vecs.push_back(v("sw_w3",  1, 6'h2B, 1, C_MWR,  0));
        vecs.push_back(v("r_f0",   1, 6'h00, 0, C_FWAIT,0));
        vecs.push_back(v("r_f1",   1, 6'h00, 0, C_FWAIT,0));
        vecs.push_back(v("r_f2",   1, 6'h00, 1, C_FRDY, 0));
        vecs.push_back(v("r_d",    1, 6'h00, 0, C_DEC,  0));
        vecs.push_back(v("r_ex",   1, 6'h00, 0, C_EX,   0));
        vecs.push_back(v("r_wb",   1, 6'h00, 0, C_AWB,  0));
        vecs.push_back(v("ai_f",   1, 6'h08, 1, C_FRDY, 0));
        vecs.push_back(v("ai_d",   1, 6'h08, 1, C_DEC,  0));
        vecs.push_back(v("ai_ix",  1, 6'h08, 0, C_IMX,  0));
        vecs.push_back(v("ai_wb",  1, 6'h08, 1, C_IWB,  0));
        vecs.push_back(v("beq_f",  1, 6'h04, 1, C_FRDY, 0));
        vecs.push_back(v("beq_d",  1, 6'h04, 1, C_DEC,  0));
        vecs.push_back(v("beq_br", 1, 6'h04, 0, C_BR,   0));
        vecs.push_back(v("j_f",    1, 6'h02, 1, C_FRDY, 0));
        vecs.push_back(v("j_d",    1, 6'h02, 1, C_DEC,  0));
        vecs.push_back(v("j_j",    1, 6'h02, 0, C_JMP,  0));
        vecs.push_back(v("xr_f",   1, 6'h00, 1, C_FRDY, 0));
        vecs.push_back(v("xr_d",   1, 6'h00, 1, C_DEC,  0));
        vecs.push_back(v("xr_ex",  0, 6'h00, 1, C_ZERO, 0));
        vecs.push_back(v("xr_hold",0, 6'h00, 1, C_ZERO, 0));
        vecs.push_back(v("xr_rel", 1, 6'h00, 1, C_FRDY, 0));
        vecs.push_back(v("xr_d2",  1, 6'h02, 1, C_DEC,  0));
        vecs.push_back(v("xr_j",   1, 6'h02, 1, C_JMP,  0));
        vecs.push_back(v("tr_f",   1, 6'h3F, 1, C_FRDY, 0));
        vecs.push_back(v("tr_d",   1, 6'h3F, 1, C_DEC,  0));
        vecs.push_back(v("tr_0",   1, 6'h3F, 1, C_ZERO, 1));
        vecs.push_back(v("tr_1",   1, 6'h23, 0, C_ZERO, 1));
        vecs.push_back(v("tr_2",   1, 6'h00, 1, C_ZERO, 1));
        vecs.push_back(v("tr_rst", 0, 6'h02, 1, C_ZERO, 0));
        vecs.push_back(v("tr_rel", 1, 6'h02, 1, C_FRDY, 0));
        vecs.push_back(v("tr_jd",  1, 6'h02, 1, C_DEC,  0));
        vecs.push_back(v("tr_jj",  1, 6'h02, 1, C_JMP,  0));

        foreach (vecs[i]) apply(vecs[i]);

`ifdef MC_PERF_CNT_EN
        apply(v("p_rst", 0, 6'h02, 1, C_ZERO, 0));
        check("p_cyc0", cycle_cnt, 32'd0);
        check("p_ins0", instr_cnt, 32'd0);
        apply(v("p_f",   1, 6'h02, 1, C_FRDY, 0));
        apply(v("p_d",   1, 6'h02, 1, C_DEC,  0));
        apply(v("p_j",   1, 6'h02, 1, C_JMP,  0));
        apply(v("q_f",   1, 6'h3F, 1, C_FRDY, 0));
        check("p_cyc3", cycle_cnt, 32'd3);
        check("p_ins1", instr_cnt, 32'd1);
        apply(v("q_d",   1, 6'h3F, 1, C_DEC,  0));
        apply(v("q_t0",  1, 6'h3F, 1, C_ZERO, 1));
        apply(v("q_t1",  1, 6'h3F, 1, C_ZERO, 1));
        apply(v("q_t2",  1, 6'h3F, 1, C_ZERO, 1));
        check("p_cycfrz", cycle_cnt, 32'd5);
        check("p_insfrz", instr_cnt, 32'd1);
`endif

        // lw with two data-read wait states: next IRWrite lands 7 cycles later
        apply(v("lat_rst", 0, 6'h23, 1, C_ZERO, 0));
        lat = -1;
        stalls = 2;
        for (int cyc = 0; cyc < 20 && lat < 0; cyc++) begin
            @(posedge clk);
            #1;
            reset_n = 1'b1;
            opcode  = 6'h23;
            if (MemRead && IorD && stalls > 0) begin
                mem_ready = 1'b0;
                stalls--;
            end else begin
                mem_ready = 1'b1;
            end
            @(negedge clk);
            if (cyc > 0 && IRWrite)
                lat = cyc;
        end
        check("lw_latency", lat, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle main control FSM for the MIPS core: the next datapath step after the single-cycle CPU, sharing one ALU and one unified memory across instruction phases.
- Takes the 6-bit opcode from the instruction register and sequences fetch/decode/execute/memory/writeback.
- Drives every datapath mux select and write enable; stalls on a memory ready handshake.
- Sits beside alucontrol, which still decodes funct from ALUOp.

Parameters:
- OP_RTYPE, 6'h00, R-type opcode
- OP_LW, 6'h23, load word opcode
- OP_SW, 6'h2B, store word opcode
- OP_BEQ, 6'h04, branch-equal opcode
- OP_J, 6'h02, jump opcode
- OP_ADDI, 6'h08, add-immediate opcode

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory completes the current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU zero (beq)
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  writeback select: 1=MDR, 0=ALUOut
- RegDst  out  1  write register select: 1=rd, 0=rt
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0=PC, 1=rs
- ALUSrcB  out  2  0=rt, 1=const 4, 2=signext, 3=signext<<2
- ALUOp  out  2  to alucontrol: 00 add, 01 sub, 10 funct
- PCSource  out  2  0=ALU result, 1=ALUOut, 2=jump target
- illegal  out  1  sticky: unsupported opcode trapped

Behaviour:
- States (4-bit): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, IMMEX=10, IMMWB=11, TRAP=12. Moore outputs decoded from state only, except that IRWrite and PCWrite in FETCH are gated by mem_ready.
- Reset: reset_n low asynchronously forces state=FETCH and illegal=0. While reset_n is low, all strobes (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite) are 0; selects are 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=00, PCSource=0. IRWrite=PCWrite=mem_ready. Hold until mem_ready, then go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=00 (branch target). Next state by opcode: LW/SW->MEMADR, RTYPE->EXEC, BEQ->BRANCH, J->JUMP, ADDI->IMMEX, other->TRAP.
- MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=00. Next is MEMRD for LW, MEMWR for SW.
- MEMRD: MemRead=1, IorD=1. Hold until mem_ready, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, then FETCH.
- MEMWR: MemWrite=1, IorD=1. Hold until mem_ready, then FETCH. MemWrite stays high for the whole stall.
- EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=10, then ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=01, PCWriteCond=1, PCSource=1, then FETCH.
- JUMP: PCWrite=1, PCSource=2, then FETCH.
- IMMEX: ALUSrcA=1, ALUSrcB=2, ALUOp=00, then IMMWB.
- IMMWB: RegWrite=1, RegDst=0, MemtoReg=0, then FETCH.
- TRAP: sets illegal=1. All strobes 0. Absorbing; leaves only on reset.
- Latency in cycles, with zero wait states: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each mem_ready-low cycle adds 1.
- mem_ready is ignored outside FETCH/MEMRD/MEMWR. opcode is sampled only in DECODE and MEMADR.
- Reset asserted mid-instruction: the instruction is abandoned, no partial write completes after the reset edge, and the FSM restarts at FETCH.

Optional Feature:
- MC_PERF_CNT_EN. When defined, adds outputs cycle_cnt[31:0] and instr_cnt[31:0], both reset to 0.
  - cycle_cnt increments every cycle while not in TRAP.
  - instr_cnt increments on every transition into FETCH from a non-FETCH state.
  - Both wrap from 32'hFFFFFFFF to 0.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Package mc_pkg holds the state encoding localparams, the opcode constants, and the ALUSrcB/PCSource/ALUOp encodings.
- Natural sub-module: mc_outdec, a purely combinational state-to-control-word decoder. mc_control keeps the state register, next-state logic, illegal flag and counters.

Test Plan:
- Reset: hold reset_n=0 mid-EXEC -> state=FETCH, all strobes 0, illegal=0. On release with mem_ready=1 -> MemRead=1 and IRWrite=1 in the first cycle.
- lw, opcode 6'h23, mem_ready=1 -> states 0,1,2,3,4 over 5 cycles; RegWrite=1, MemtoReg=1 only in cycle 5.
- sw, opcode 6'h2B, mem_ready low for 3 cycles in MEMWR -> MemWrite=1, IorD=1 for 4 cycles, then FETCH; total 7 cycles.
- Fetch stall: mem_ready=0 for 2 cycles in FETCH -> IRWrite=PCWrite=0 those cycles, =1 only in the third.
- beq (6'h04) -> BRANCH with ALUOp=01, PCWriteCond=1, PCSource=1. j (6'h02) -> PCWrite=1, PCSource=2. Each takes 3 cycles.
- Illegal opcode 6'h3F -> TRAP, illegal=1, no strobes thereafter. With MC_PERF_CNT_EN, cycle_cnt freezes and instr_cnt is unchanged.
